// File: rtl/hls_ctrl_master.sv
// hls_ctrl_master: AXI4-Lite initiator that writes ap_start to the HLS ap_ctrl register, then polls it until ap_done.
// Latency: done pulses 6 cycles after start (zero-wait slave, POLL_GAP=0, ap_done on the first read).
// Backpressure: each VALID is held until its READY; BREADY/RREADY are raised only while a response is outstanding.
//
// Ports: clk, rst (synchronous, active-high); start/busy/done launch and retire a run; err and timeout are
// sticky until the next accepted start; status holds RDATA of the last completed read; poll_cnt counts
// completed poll reads (saturating); m_axi_* is the AXI4-Lite master toward the s_axi_config slave.
module hls_ctrl_master #(
    parameter int unsigned C_S_AXI_CONFIG_ADDR_WIDTH = 5,
    parameter int unsigned C_S_AXI_CONFIG_DATA_WIDTH = 32,
    parameter int unsigned CTRL_ADDR                 = 0,
    parameter int unsigned POLL_GAP                  = 4,
    parameter int unsigned MAX_POLLS                 = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err,
    output logic                                     timeout,
    output logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]     status,
    output logic [15:0]                              poll_cnt,
    output logic                                     m_axi_AWVALID,
    input  logic                                     m_axi_AWREADY,
    output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]     m_axi_AWADDR,
    output logic                                     m_axi_WVALID,
    input  logic                                     m_axi_WREADY,
    output logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]     m_axi_WDATA,
    output logic [C_S_AXI_CONFIG_DATA_WIDTH/8-1:0]   m_axi_WSTRB,
    input  logic                                     m_axi_BVALID,
    output logic                                     m_axi_BREADY,
    input  logic [1:0]                               m_axi_BRESP,
    output logic                                     m_axi_ARVALID,
    input  logic                                     m_axi_ARREADY,
    output logic [C_S_AXI_CONFIG_ADDR_WIDTH-1:0]     m_axi_ARADDR,
    input  logic                                     m_axi_RVALID,
    output logic                                     m_axi_RREADY,
    input  logic [C_S_AXI_CONFIG_DATA_WIDTH-1:0]     m_axi_RDATA,
    input  logic [1:0]                               m_axi_RRESP
);
    localparam int unsigned AW = C_S_AXI_CONFIG_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_CONFIG_DATA_WIDTH;
    localparam logic [AW-1:0] CTRL_A      = AW'(CTRL_ADDR);
    localparam logic [DW-1:0] START_WORD  = {{(DW-1){1'b0}}, 1'b1};
    // GAP always lasts at least one cycle, so the counter is loaded with POLL_GAP-1 (0 when POLL_GAP is 0).
    localparam logic [31:0]   GAP_LOAD    = (POLL_GAP == 0) ? 32'd0 : 32'(POLL_GAP - 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, GAP, RD_REQ, RD_RESP, FIN} state_t;

    state_t         state_q, state_d;
    logic           aw_ok_q, aw_ok_d;
    logic           w_ok_q, w_ok_d;
    logic [31:0]    gap_cnt_q, gap_cnt_d;
    logic           done_d, busy_d, err_d, timeout_d;
    logic [DW-1:0]  status_d;
    logic [15:0]    poll_cnt_d, poll_cnt_inc;
    logic           awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic           aw_hs, w_hs, last_poll;

    always_comb begin
        state_d      = state_q;
        aw_ok_d      = aw_ok_q;
        w_ok_d       = w_ok_q;
        gap_cnt_d    = gap_cnt_q;
        err_d        = err;
        timeout_d    = timeout;
        status_d     = status;
        poll_cnt_d   = poll_cnt;
        awvalid_d    = m_axi_AWVALID;
        wvalid_d     = m_axi_WVALID;
        bready_d     = m_axi_BREADY;
        arvalid_d    = m_axi_ARVALID;
        rready_d     = m_axi_RREADY;
        aw_hs        = m_axi_AWVALID & m_axi_AWREADY;
        w_hs         = m_axi_WVALID & m_axi_WREADY;
        poll_cnt_inc = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
        // Compare the pre-increment count so the read that reaches MAX_POLLS is the last one.
        last_poll    = (MAX_POLLS != 0) && (({16'd0, poll_cnt} + 32'd1) == MAX_POLLS);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = WR_REQ;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    err_d      = 1'b0;
                    timeout_d  = 1'b0;
                    poll_cnt_d = '0;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; each VALID drops right after its own handshake.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_ok_d   = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_ok_d   = 1'b1;
                end
                if ((aw_ok_q | aw_hs) & (w_ok_q | w_hs)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                    aw_ok_d  = 1'b0;
                    w_ok_d   = 1'b0;
                end
            end
            WR_RESP: begin
                if (m_axi_BVALID) begin
                    bready_d = 1'b0;
                    if (m_axi_BRESP != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 32'd0) begin
                    state_d   = RD_REQ;
                    arvalid_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end
            end
            RD_REQ: begin
                if (m_axi_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_RVALID) begin
                    rready_d   = 1'b0;
                    status_d   = m_axi_RDATA;
                    poll_cnt_d = poll_cnt_inc;
                    if (m_axi_RRESP != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else if (m_axi_RDATA[1]) begin
                        state_d = FIN;
                    end else if (last_poll) begin
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = FIN;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == FIN);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            aw_ok_q       <= 1'b0;
            w_ok_q        <= 1'b0;
            gap_cnt_q     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            timeout       <= 1'b0;
            status        <= '0;
            poll_cnt      <= '0;
            m_axi_AWVALID <= 1'b0;
            m_axi_WVALID  <= 1'b0;
            m_axi_BREADY  <= 1'b0;
            m_axi_ARVALID <= 1'b0;
            m_axi_RREADY  <= 1'b0;
            m_axi_AWADDR  <= CTRL_A;
            m_axi_ARADDR  <= CTRL_A;
            m_axi_WDATA   <= START_WORD;
            m_axi_WSTRB   <= '1;
        end else begin
            state_q       <= state_d;
            aw_ok_q       <= aw_ok_d;
            w_ok_q        <= w_ok_d;
            gap_cnt_q     <= gap_cnt_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
            timeout       <= timeout_d;
            status        <= status_d;
            poll_cnt      <= poll_cnt_d;
            m_axi_AWVALID <= awvalid_d;
            m_axi_WVALID  <= wvalid_d;
            m_axi_BREADY  <= bready_d;
            m_axi_ARVALID <= arvalid_d;
            m_axi_RREADY  <= rready_d;
            m_axi_AWADDR  <= CTRL_A;
            m_axi_ARADDR  <= CTRL_A;
            m_axi_WDATA   <= START_WORD;
            m_axi_WSTRB   <= '1;
        end
    end
endmodule

// File: tb/tb_hls_ctrl_master.sv
// tb_hls_ctrl_master: two instances (POLL_GAP=0/MAX_POLLS=3 and POLL_GAP=4/MAX_POLLS=0) against a
// configurable AXI-Lite slave; each run's outcome is predicted from the polling rules.
// Slave readiness is configurable per channel; responses follow a handshake by one cycle.
module tb_hls_ctrl_master;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start   [2];
    logic          busy    [2];
    logic          done_o  [2];
    logic          err_o   [2];
    logic          tmo     [2];
    logic [DW-1:0] status  [2];
    logic [15:0]   pcnt    [2];
    logic          awvalid [2], awready [2], wvalid [2], wready [2];
    logic [AW-1:0] awaddr  [2], araddr  [2];
    logic [DW-1:0] wdata   [2], rdata   [2];
    logic [3:0]    wstrb   [2];
    logic          bvalid  [2], bready  [2], arvalid [2], arready [2], rvalid [2], rready [2];
    logic [1:0]    bresp   [2], rresp   [2];

    // Per-instance slave configuration, written only by the stimulus process.
    int            aw_dly [2], w_dly [2], ar_dly [2], done_at [2], rerr_at [2];
    logic [1:0]    cfg_bresp [2];
    logic [31:0]   busy_word [2], done_word [2];

    // Slave and monitor state.
    int            aw_wait [2], w_wait [2], ar_wait [2], rd_cnt [2];
    logic          aw_got [2], w_got [2];
    int            n_aw [2], n_w [2], n_ar [2], n_done [2], aw_hi [2], w_hi [2];
    int            viol [2], bad_wr [2], last_rise [2], min_gap [2];
    logic          p_awv [2], p_awr [2], p_wv [2], p_wr [2], p_arv [2], p_arr [2], p_rst [2];
    logic          m_aw_seen [2], m_w_seen [2];
    logic [AW-1:0] p_awa [2], p_ara [2];
    logic [DW-1:0] p_wd [2];
    logic [3:0]    p_ws [2];
    int            cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_chk = 0;
    int            n_pass = 0;
    logic [31:0]   exp_status [2];

    function automatic logic [31:0] slave_word(input int i, input int k);
        if (k == done_at[i]) return done_word[i] | 32'h2;
        return (busy_word[i] + 32'(k)) & ~32'h2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_inst
        hls_ctrl_master #(
            .C_S_AXI_CONFIG_ADDR_WIDTH(AW),
            .C_S_AXI_CONFIG_DATA_WIDTH(DW),
            .CTRL_ADDR(0),
            .POLL_GAP((g == 0) ? 0 : 4),
            .MAX_POLLS((g == 0) ? 3 : 0)
        ) dut (
            .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done_o[g]),
            .err(err_o[g]), .timeout(tmo[g]), .status(status[g]), .poll_cnt(pcnt[g]),
            .m_axi_AWVALID(awvalid[g]), .m_axi_AWREADY(awready[g]), .m_axi_AWADDR(awaddr[g]),
            .m_axi_WVALID(wvalid[g]), .m_axi_WREADY(wready[g]), .m_axi_WDATA(wdata[g]),
            .m_axi_WSTRB(wstrb[g]), .m_axi_BVALID(bvalid[g]), .m_axi_BREADY(bready[g]),
            .m_axi_BRESP(bresp[g]), .m_axi_ARVALID(arvalid[g]), .m_axi_ARREADY(arready[g]),
            .m_axi_ARADDR(araddr[g]), .m_axi_RVALID(rvalid[g]), .m_axi_RREADY(rready[g]),
            .m_axi_RDATA(rdata[g]), .m_axi_RRESP(rresp[g])
        );

        assign awready[g] = (aw_wait[g] >= aw_dly[g]);
        assign wready[g]  = (w_wait[g]  >= w_dly[g]);
        assign arready[g] = (ar_wait[g] >= ar_dly[g]);

        always @(posedge clk) begin
            if (rst) begin
                aw_wait[g] <= 0; w_wait[g] <= 0; ar_wait[g] <= 0; rd_cnt[g] <= 0;
                aw_got[g] <= 1'b0; w_got[g] <= 1'b0;
                bvalid[g] <= 1'b0; bresp[g] <= 2'b00;
                rvalid[g] <= 1'b0; rresp[g] <= 2'b00; rdata[g] <= '0;
            end else begin
                if (start[g]) rd_cnt[g] <= 0;
                if (awvalid[g] && awready[g]) aw_wait[g] <= 0;
                else if (awvalid[g])          aw_wait[g] <= aw_wait[g] + 1;
                if (wvalid[g] && wready[g])   w_wait[g] <= 0;
                else if (wvalid[g])           w_wait[g] <= w_wait[g] + 1;
                if (arvalid[g] && arready[g]) ar_wait[g] <= 0;
                else if (arvalid[g])          ar_wait[g] <= ar_wait[g] + 1;
                if ((aw_got[g] || (awvalid[g] && awready[g])) && (w_got[g] || (wvalid[g] && wready[g]))) begin
                    bvalid[g] <= 1'b1;
                    bresp[g]  <= cfg_bresp[g];
                    aw_got[g] <= 1'b0;
                    w_got[g]  <= 1'b0;
                end else begin
                    if (awvalid[g] && awready[g]) aw_got[g] <= 1'b1;
                    if (wvalid[g] && wready[g])   w_got[g]  <= 1'b1;
                    if (bvalid[g] && bready[g])   bvalid[g] <= 1'b0;
                end
                if (arvalid[g] && arready[g]) begin
                    rvalid[g] <= 1'b1;
                    rdata[g]  <= slave_word(g, rd_cnt[g] + 1);
                    rresp[g]  <= (rd_cnt[g] + 1 == rerr_at[g]) ? 2'b10 : 2'b00;
                    rd_cnt[g] <= rd_cnt[g] + 1;
                end else if (rvalid[g] && rready[g]) begin
                    rvalid[g] <= 1'b0;
                end
            end
        end

        always @(negedge clk) begin : mon
            int v;
            v = 0;
            if (!p_rst[g] && p_awv[g] && !p_awr[g] && (!awvalid[g] || awaddr[g] != p_awa[g])) v++;
            if (!p_rst[g] && p_wv[g] && !p_wr[g] && (!wvalid[g] || wdata[g] != p_wd[g] || wstrb[g] != p_ws[g])) v++;
            if (!p_rst[g] && p_arv[g] && !p_arr[g] && (!arvalid[g] || araddr[g] != p_ara[g])) v++;
            if (bready[g] && !(m_aw_seen[g] && m_w_seen[g])) v++;
            if (rst || start[g]) begin
                n_aw[g] <= 0; n_w[g] <= 0; n_ar[g] <= 0; n_done[g] <= 0; aw_hi[g] <= 0; w_hi[g] <= 0;
                viol[g] <= 0; bad_wr[g] <= 0; last_rise[g] <= -1; min_gap[g] <= 1000000;
                m_aw_seen[g] <= 1'b0; m_w_seen[g] <= 1'b0;
            end else begin
                n_aw[g]   <= n_aw[g] + ((awvalid[g] && awready[g]) ? 1 : 0);
                n_w[g]    <= n_w[g] + ((wvalid[g] && wready[g]) ? 1 : 0);
                n_ar[g]   <= n_ar[g] + ((arvalid[g] && arready[g]) ? 1 : 0);
                n_done[g] <= n_done[g] + (done_o[g] ? 1 : 0);
                aw_hi[g]  <= aw_hi[g] + (awvalid[g] ? 1 : 0);
                w_hi[g]   <= w_hi[g] + (wvalid[g] ? 1 : 0);
                viol[g]   <= viol[g] + v;
                bad_wr[g] <= bad_wr[g] + ((awvalid[g] && awready[g] && awaddr[g] != '0) ? 1 : 0)
                                       + ((wvalid[g] && wready[g] && (wdata[g] != 32'd1 || wstrb[g] != 4'hF)) ? 1 : 0);
                if (awvalid[g] && awready[g]) m_aw_seen[g] <= 1'b1;
                if (wvalid[g] && wready[g])   m_w_seen[g]  <= 1'b1;
                if (arvalid[g] && !p_arv[g]) begin
                    if (last_rise[g] >= 0 && cyc - last_rise[g] < min_gap[g]) min_gap[g] <= cyc - last_rise[g];
                    last_rise[g] <= cyc;
                end
            end
            p_awv[g] <= awvalid[g]; p_awr[g] <= awready[g]; p_awa[g] <= awaddr[g];
            p_wv[g]  <= wvalid[g];  p_wr[g]  <= wready[g];  p_wd[g]  <= wdata[g]; p_ws[g] <= wstrb[g];
            p_arv[g] <= arvalid[g]; p_arr[g] <= arready[g]; p_ara[g] <= araddr[g];
            p_rst[g] <= rst;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_cfg(input int i, input int awd, input int wd, input int ard, input int dat,
                           input int rerr, input logic [1:0] br, input logic [31:0] bw, input logic [31:0] dw);
        aw_dly[i] = awd; w_dly[i] = wd; ar_dly[i] = ard; done_at[i] = dat; rerr_at[i] = rerr;
        cfg_bresp[i] = br; busy_word[i] = bw; done_word[i] = dw;
    endtask

    // Reference: replay the polling rules read by read until the run must end.
    task automatic check_run(input int i, input string nm);
        int reads, maxp, pg;
        logic e, t;
        logic [31:0] st;
        maxp = (i == 0) ? 3 : 0;
        pg   = (i == 0) ? 0 : 4;
        reads = 0; e = 1'b0; t = 1'b0; st = exp_status[i];
        if (cfg_bresp[i] != 2'b00) begin
            e = 1'b1;
        end else begin
            for (int k = 1; k <= 64; k++) begin
                reads = k;
                st = slave_word(i, k);
                if (rerr_at[i] == k) begin e = 1'b1; break; end
                if (done_at[i] == k) break;
                if (maxp != 0 && k == maxp) begin e = 1'b1; t = 1'b1; break; end
            end
        end
        exp_status[i] = st;
        check_val({nm, ".reads"},    n_ar[i], reads);
        check_val({nm, ".poll_cnt"}, {16'd0, pcnt[i]}, reads);
        check_val({nm, ".status"},   status[i], st);
        check_val({nm, ".err"},      err_o[i], e);
        check_val({nm, ".timeout"},  tmo[i], t);
        check_val({nm, ".done_cnt"}, n_done[i], 1);
        check_val({nm, ".writes"},   n_aw[i] + n_w[i], 2);
        check_val({nm, ".protocol"}, viol[i], 0);
        check_val({nm, ".wr_fields"}, bad_wr[i], 0);
        if (reads > 1) check_val({nm, ".poll_gap"}, min_gap[i] >= ((pg == 0) ? 1 : pg) + 2, 1);
    endtask

    task automatic run(input int i, input string nm, output int lat);
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        lat = 1;
        check_val({nm, ".busy_on_start"}, busy[i], 1);
        check_val({nm, ".err_clr"}, err_o[i], 0);
        check_val({nm, ".tmo_clr"}, tmo[i], 0);
        while (!done_o[i] && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({nm, ".done_seen"}, done_o[i], 1);
        repeat (3) @(posedge clk);
        #1;
        check_run(i, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k, i;
        for (int j = 0; j < 2; j++) begin
            start[j] = 1'b0;
            exp_status[j] = '0;
            set_cfg(j, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h6);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            check_val($sformatf("rst%0d.valids", j), {awvalid[j], wvalid[j], arvalid[j], bready[j], rready[j]}, 0);
            check_val($sformatf("rst%0d.flags", j), {busy[j], done_o[j], err_o[j], tmo[j]}, 0);
            check_val($sformatf("rst%0d.status", j), status[j], 0);
            check_val($sformatf("rst%0d.poll_cnt", j), pcnt[j], 0);
            check_val($sformatf("rst%0d.addr", j), {awaddr[j], araddr[j]}, 0);
            check_val($sformatf("rst%0d.wdata", j), wdata[j], 1);
            check_val($sformatf("rst%0d.wstrb", j), wstrb[j], 4'hF);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait slave, ap_done on the first read.
        set_cfg(0, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h6);
        run(0, "zero_wait", lat);
        check_val("zero_wait.latency", lat, 6);
        check_val("zero_wait.status6", status[0], 32'h6);

        // AWREADY three cycles late, WREADY immediate.
        set_cfg(0, 3, 0, 0, 1, 0, 2'b00, 32'h0, 32'h6);
        run(0, "aw_late", lat);
        check_val("aw_late.aw_hi", aw_hi[0], 4);
        check_val("aw_late.w_hi", w_hi[0], 1);

        // ap_done on the 5th read with POLL_GAP=4.
        set_cfg(1, 0, 0, 0, 5, 0, 2'b00, 32'h1230, 32'h4);
        run(1, "done5", lat);
        check_val("done5.gap6", min_gap[1] >= 6, 1);

        // MAX_POLLS=3 with ap_done never set, then a clean run clears the sticky flags.
        set_cfg(0, 0, 0, 0, 0, 0, 2'b00, 32'hA0, 32'h0);
        run(0, "timeout", lat);
        set_cfg(0, 0, 0, 0, 1, 0, 2'b00, 32'h0, 32'h6);
        run(0, "after_tmo", lat);

        // Write response error: no reads issued.
        set_cfg(1, 0, 0, 0, 1, 0, 2'b10, 32'h0, 32'h2);
        run(1, "bresp_err", lat);

        // Reset while ARVALID is stalled.
        set_cfg(1, 0, 0, 1000, 1, 0, 2'b00, 32'h0, 32'h2);
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        k = 0;
        while (!arvalid[1] && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("rst_mid.arvalid_seen", arvalid[1], 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid.valids", {awvalid[1], wvalid[1], arvalid[1], bready[1], rready[1]}, 0);
        check_val("rst_mid.flags", {busy[1], done_o[1], err_o[1], tmo[1]}, 0);
        check_val("rst_mid.status", status[1], 0);
        check_val("rst_mid.poll_cnt", pcnt[1], 0);
        rst = 1'b0;
        exp_status[0] = '0;
        exp_status[1] = '0;
        ar_dly[1] = 0;
        @(posedge clk); #1;
        run(1, "rst_after", lat);

        // Randomized runs on both instances.
        for (int n = 0; n < 24; n++) begin
            i = $urandom_range(0, 1);
            set_cfg(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    (i == 0) ? $urandom_range(0, 4) : $urandom_range(1, 4),
                    ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0,
                    ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom, $urandom);
            run(i, $sformatf("rnd%0d_i%0d", n, i), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
